// File: rtl/unified_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory block.
package unified_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    // Widest word the byte-merge helper supports; callers cast in and out.
    localparam int MAX_DATA_W = 256;

    typedef enum logic {IDLE, SWEEP} clear_state_t;

    typedef logic [MAX_DATA_W-1:0]   wide_word_t;
    typedef logic [MAX_DATA_W/8-1:0] wide_be_t;

    function automatic wide_word_t byte_merge(wide_word_t old_word, wide_word_t new_word,
                                              wide_be_t be);
        wide_word_t merged;
        merged = old_word;
        for (int b = 0; b < MAX_DATA_W / 8; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/unified_mem_if.sv
// Fetch port, data port and sweep control bundle of the unified memory.
interface unified_mem_if import unified_mem_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                  FetchReq;
    logic [ADDR_W-1:0]     FetchAddr;
    logic                  FetchValid;
    logic [DATA_W-1:0]     Instr;
    logic                  DataReq;
    logic                  DataWe;
    logic [ADDR_W-1:0]     DataAddr;
    logic [DATA_W-1:0]     WData;
    logic [DATA_W/8-1:0]   ByteEn;
    logic                  DataAck;
    logic [DATA_W-1:0]     RData;
    logic                  ClearAll;
    logic                  Busy;
    logic                  AddrErr;

    modport master (
        output FetchReq, FetchAddr, DataReq, DataWe, DataAddr, WData, ByteEn, ClearAll,
        input  FetchValid, Instr, DataAck, RData, Busy, AddrErr
    );

    modport slave (
        input  FetchReq, FetchAddr, DataReq, DataWe, DataAddr, WData, ByteEn, ClearAll,
        output FetchValid, Instr, DataAck, RData, Busy, AddrErr
    );
endinterface

// File: rtl/mem_clear_fsm.sv
// Bulk-clear engine: walks sweep_ptr over 0..DEPTH-1, one zeroed word per cycle.
module mem_clear_fsm import unified_mem_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ClearAll,
    output logic              Busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clear_state_t      state, state_next;
    logic [ADDR_W-1:0] sweep_ptr, ptr_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            sweep_ptr <= '0;
        end else begin
            state     <= state_next;
            sweep_ptr <= ptr_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ptr_next   = sweep_ptr;
        case (state)
            IDLE: begin
                if (ClearAll) begin
                    state_next = SWEEP;
                    ptr_next   = '0;
                end
            end
            SWEEP: begin
                if (sweep_ptr == LAST_IDX) state_next = IDLE;
                else                       ptr_next   = sweep_ptr + ADDR_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // A reset landing mid-sweep must not clear the word currently pointed at.
    assign Busy       = (state == SWEEP);
    assign sweep_we   = Busy && !Reset;
    assign sweep_addr = sweep_ptr;

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory: 1-cycle fetch port, byte-enabled data port,
// bulk-clear sweep and out-of-range address reporting.
module unified_mem_ctrl import unified_mem_pkg::*; #(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    DEPTH     = DEF_DEPTH,
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter string INIT_FILE = "memoria.txt"
) (
    input  logic              Clk,
    input  logic              Reset,
    unified_mem_if.slave      bus
);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              fetch_go, data_go, write_go;
    logic              fetch_ok, data_ok;
    logic [DATA_W-1:0] write_word;

    mem_clear_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clear (
        .Clk        (Clk),
        .Reset      (Reset),
        .ClearAll   (bus.ClearAll),
        .Busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    assign bus.Busy = busy;

    assign fetch_go = bus.FetchReq && !busy;
    assign data_go  = bus.DataReq && !busy;
    assign write_go = data_go && bus.DataWe && !Reset;
    assign fetch_ok = {1'b0, bus.FetchAddr} < DEPTH_V;
    assign data_ok  = {1'b0, bus.DataAddr} < DEPTH_V;

    assign write_word = DATA_W'(byte_merge(wide_word_t'(mem[bus.DataAddr]),
                                           wide_word_t'(bus.WData),
                                           wide_be_t'(bus.ByteEn)));

    // NOTE: the array is deliberately not reset; only the sweep and data writes change it.
    always_ff @(posedge Clk) begin
        if (sweep_we)                mem[sweep_addr]   <= '0;
        else if (write_go && data_ok) mem[bus.DataAddr] <= write_word;
    end

    // NOTE: non-blocking reads sample the pre-edge array, which gives read-before-write
    // when a fetch and a write hit the same word in one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.FetchValid <= 1'b0;
            bus.Instr      <= '0;
            bus.DataAck    <= 1'b0;
            bus.RData      <= '0;
            bus.AddrErr    <= 1'b0;
        end else begin
            bus.FetchValid <= fetch_go;
            bus.DataAck    <= data_go;
            bus.AddrErr    <= (fetch_go && !fetch_ok) || (data_go && !data_ok);
            if (fetch_go)                 bus.Instr <= fetch_ok ? mem[bus.FetchAddr] : '0;
            if (data_go && !bus.DataWe)   bus.RData <= data_ok ? mem[bus.DataAddr] : '0;
        end
    end

endmodule
